// File: rtl/cal_pkg.sv
// Shared types and LED code helper for the calibration sequencer.
// Define CAL_GRAY_EN to emit Gray-coded LED IDs instead of plain binary.
package cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHOW,
        SCAN,
        DONE
    } cal_state_t;

    // Code 0 is reserved for "no LED", so LED j carries j+1 before optional Gray mapping.
    function automatic int unsigned led_code(input int unsigned j);
        int unsigned c;
        c = j + 1;
`ifdef CAL_GRAY_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

endpackage

// File: rtl/cal_led_encoder.sv
// Registered LED-request to colour path: lights an LED when the active plane's bit
// of its code is set while a plane is being shown or scanned.
module cal_led_encoder
    import cal_pkg::*;
#(
    parameter int unsigned NUM_LEDS          = 50,
    parameter int unsigned LED_ADDRESS_WIDTH = 6,
    parameter int unsigned KW                = 3,
    parameter logic [23:0] ON_COLOR          = 24'hFFFFFF,
    parameter logic [23:0] OFF_COLOR         = 24'h000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LED_ADDRESS_WIDTH-1:0] led_request,
    input  logic                         led_request_valid,
    input  logic [KW-1:0]                k,
    input  cal_state_t                   state,
    output logic [7:0]                   red_out,
    output logic [7:0]                   green_out,
    output logic [7:0]                   blue_out,
    output logic                         color_valid
);

    logic [31:0] w_code;
    logic        w_lit;

    always_comb begin
        w_code = led_code(32'(led_request));
        w_lit  = ((state == SHOW) || (state == SCAN)) &&
                 (32'(led_request) < NUM_LEDS) &&
                 (|(w_code & (32'd1 << k)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
            color_valid <= 1'b0;
        end else begin
            color_valid <= led_request_valid;
            if (led_request_valid && w_lit) begin
                red_out   <= ON_COLOR[23:16];
                green_out <= ON_COLOR[15:8];
                blue_out  <= ON_COLOR[7:0];
            end else begin
                red_out   <= OFF_COLOR[23:16];
                green_out <= OFF_COLOR[15:8];
                blue_out  <= OFF_COLOR[7:0];
            end
        end
    end

endmodule

// File: rtl/cal_sequencer.sv
// Calibration sequencer: shows one LED-ID bit-plane at a time and ORs each captured
// plane into the per-pixel calibration table. CAL_GRAY_EN selects Gray-coded IDs.
module cal_sequencer
    import cal_pkg::*;
#(
    parameter int unsigned NUM_LEDS                = 50,
    parameter int unsigned LED_ADDRESS_WIDTH       = 6,
    parameter int unsigned NUM_FRAME_BUFFER_PIXELS = 64800,
    parameter int unsigned SETTLE_CYCLES           = 1024,
    parameter logic [23:0] ON_COLOR                = 24'hFFFFFF,
    parameter logic [23:0] OFF_COLOR               = 24'h000000
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       capture_frame,
    input  logic [LED_ADDRESS_WIDTH-1:0]               led_request,
    input  logic                                       led_request_valid,
    output logic [7:0]                                 red_out,
    output logic [7:0]                                 green_out,
    output logic [7:0]                                 blue_out,
    output logic                                       color_valid,
    output logic                                       displayed_frame_valid,
    output logic [$clog2(NUM_FRAME_BUFFER_PIXELS)-1:0] fb_addr,
    input  logic                                       fb_data,
    output logic [$clog2(NUM_FRAME_BUFFER_PIXELS)-1:0] tbl_rd_addr,
    input  logic [LED_ADDRESS_WIDTH:0]                 tbl_rd_data,
    output logic [$clog2(NUM_FRAME_BUFFER_PIXELS)-1:0] tbl_wr_addr,
    output logic [LED_ADDRESS_WIDTH:0]                 tbl_wr_data,
    output logic                                       tbl_we,
    output logic                                       busy,
    output logic                                       done,
    output logic [$clog2(LED_ADDRESS_WIDTH+1)-1:0]     current_bit
);

    localparam int unsigned CW = LED_ADDRESS_WIDTH + 1;
    localparam int unsigned PW = $clog2(NUM_FRAME_BUFFER_PIXELS);
    localparam int unsigned KW = $clog2(CW);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [PW-1:0] LAST_ADDR = PW'(NUM_FRAME_BUFFER_PIXELS - 1);

    cal_state_t    r_state, w_next;
    logic [PW-1:0] r_addr, r_a1, r_a2;
    logic          r_issue, r_v1, r_v2;
    logic [KW-1:0] r_k;
    logic [SW-1:0] r_settle;
    logic          w_settled, w_clr_last, w_scan_last, w_last_plane;

    assign w_clr_last   = (r_addr == LAST_ADDR);
    assign w_settled    = (r_state == SHOW) && (r_settle == SW'(SETTLE_CYCLES));
    assign w_scan_last  = r_v2 && (r_a2 == LAST_ADDR);
    assign w_last_plane = (r_k == KW'(CW - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next                = r_state;
        busy                  = 1'b0;
        done                  = 1'b0;
        displayed_frame_valid = w_settled;
        case (r_state)
            IDLE:  if (start) w_next = CLEAR;
            DONE: begin
                done = 1'b1;
                if (start) w_next = CLEAR;
            end
            CLEAR: begin
                busy = 1'b1;
                if (w_clr_last) w_next = SHOW;
            end
            SHOW: begin
                busy = 1'b1;
                if (capture_frame && w_settled) w_next = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (w_scan_last) w_next = w_last_plane ? DONE : SHOW;
            end
            default: w_next = IDLE;
        endcase
    end

    // Read issue and the 2-stage read-modify-write pipeline share r_addr as sweep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_a1     <= '0;
            r_a2     <= '0;
            r_issue  <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_k      <= '0;
            r_settle <= '0;
        end else begin
            r_v1 <= (r_state == SCAN) && r_issue;
            r_a1 <= r_addr;
            r_v2 <= r_v1;
            r_a2 <= r_a1;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_addr   <= '0;
                        r_k      <= '0;
                        r_settle <= '0;
                    end
                end
                CLEAR: begin
                    r_settle <= '0;
                    if (w_clr_last) r_addr <= '0;
                    else            r_addr <= r_addr + 1'b1;
                end
                SHOW: begin
                    if (!w_settled) r_settle <= r_settle + 1'b1;
                    if (w_next == SCAN) begin
                        r_addr  <= '0;
                        r_issue <= 1'b1;
                    end
                end
                SCAN: begin
                    if (r_issue) begin
                        if (r_addr == LAST_ADDR) r_issue <= 1'b0;
                        else                     r_addr  <= r_addr + 1'b1;
                    end
                    if (w_scan_last) begin
                        r_addr   <= '0;
                        r_settle <= '0;
                        if (!w_last_plane) r_k <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fb_addr     = r_addr;
        tbl_rd_addr = r_addr;
        tbl_we      = r_v2 || (r_state == CLEAR);
        tbl_wr_addr = '0;
        tbl_wr_data = '0;
        if (r_v2) begin
            tbl_wr_addr = r_a2;
            tbl_wr_data = tbl_rd_data | (CW'(fb_data) << r_k);
        end else if (r_state == CLEAR) begin
            tbl_wr_addr = r_addr;
        end
        current_bit = r_k;
    end

    cal_led_encoder #(
        .NUM_LEDS          (NUM_LEDS),
        .LED_ADDRESS_WIDTH (LED_ADDRESS_WIDTH),
        .KW                (KW),
        .ON_COLOR          (ON_COLOR),
        .OFF_COLOR         (OFF_COLOR)
    ) u_led_encoder (
        .clk               (clk),
        .rst               (rst),
        .led_request       (led_request),
        .led_request_valid (led_request_valid),
        .k                 (r_k),
        .state             (r_state),
        .red_out           (red_out),
        .green_out         (green_out),
        .blue_out          (blue_out),
        .color_valid       (color_valid)
    );

endmodule

// File: tb/tb_cal_sequencer.sv
// Directed bench for cal_sequencer with a 16-pixel table/frame-buffer model.
// Expected LED-4 code follows CAL_GRAY_EN (binary 5, Gray 7).
module tb_cal_sequencer;

    localparam int unsigned N  = 16;
    localparam int unsigned S  = 4;
    localparam int unsigned PW = 4;
    localparam int unsigned CW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          capture_frame = 1'b0;
    logic [5:0]    led_request = '0;
    logic          led_request_valid = 1'b0;
    logic [7:0]    red_out, green_out, blue_out;
    logic          color_valid, displayed_frame_valid;
    logic [PW-1:0] fb_addr, tbl_rd_addr, tbl_wr_addr;
    logic          fb_data;
    logic [CW-1:0] tbl_rd_data, tbl_wr_data;
    logic          tbl_we, busy, done;
    logic [2:0]    current_bit;

    logic [CW-1:0] mem [N];
    logic [PW-1:0] rd_a1, rd_a2, fb_a1, fb_a2;
    logic          tb_lit = 1'b0;
`ifdef CAL_GRAY_EN
    logic [CW-1:0] tb_code4 = 7'd7;
`else
    logic [CW-1:0] tb_code4 = 7'd5;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    cal_sequencer #(
        .NUM_LEDS                (50),
        .LED_ADDRESS_WIDTH       (6),
        .NUM_FRAME_BUFFER_PIXELS (N),
        .SETTLE_CYCLES           (S)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .capture_frame         (capture_frame),
        .led_request           (led_request),
        .led_request_valid     (led_request_valid),
        .red_out               (red_out),
        .green_out             (green_out),
        .blue_out              (blue_out),
        .color_valid           (color_valid),
        .displayed_frame_valid (displayed_frame_valid),
        .fb_addr               (fb_addr),
        .fb_data               (fb_data),
        .tbl_rd_addr           (tbl_rd_addr),
        .tbl_rd_data           (tbl_rd_data),
        .tbl_wr_addr           (tbl_wr_addr),
        .tbl_wr_data           (tbl_wr_data),
        .tbl_we                (tbl_we),
        .busy                  (busy),
        .done                  (done),
        .current_bit           (current_bit)
    );

    // External BRAM and frame buffer, both with 2-cycle read latency.
    always @(posedge clk) begin
        if (tbl_we) mem[tbl_wr_addr] <= tbl_wr_data;
        rd_a1 <= tbl_rd_addr;
        rd_a2 <= rd_a1;
        fb_a1 <= fb_addr;
        fb_a2 <= fb_a1;
    end
    assign tbl_rd_data = mem[rd_a2];
    assign fb_data     = (fb_a2 == 4'd7) ? tb_lit : (fb_a2 == 4'd12);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dfv();
        int unsigned n = 0;
        while (!displayed_frame_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq("settle_timeout", 32'(displayed_frame_valid), 32'd1);
    endtask

    task automatic do_plane(input int unsigned p);
        wait_dfv();
        tb_lit = tb_code4[p];
        capture_frame = 1'b1;
        tick();
        capture_frame = 1'b0;
        repeat (N + 2) tick();
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) mem[i] = 7'h55;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nz;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_we", 32'(tbl_we), 0);
        check_eq("rst_red", 32'(red_out), 0);
        check_eq("rst_cvalid", 32'(color_valid), 0);
        check_eq("rst_bit", 32'(current_bit), 0);
        check_eq("rst_dfv", 32'(displayed_frame_valid), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("clr_wdata0", 32'(tbl_wr_data), 0);
        for (int c = 0; c < int'(N); c++) begin
            check_eq("clr_we", 32'(tbl_we), 1);
            check_eq("clr_addr", 32'(tbl_wr_addr), 32'(c));
            tick();
        end
        check_eq("show_we", 32'(tbl_we), 0);
        check_eq("show0_dfv", 32'(displayed_frame_valid), 0);

        // Early capture is ignored; settle completes 4 cycles into SHOW.
        tick();
        tick();
        capture_frame = 1'b1;
        tick();
        capture_frame = 1'b0;
        check_eq("early_cap_busy", 32'(busy), 1);
        check_eq("early_cap_dfv", 32'(displayed_frame_valid), 0);
        check_eq("early_cap_rd", 32'(tbl_rd_addr), 0);
        tick();
        check_eq("settle4_dfv", 32'(displayed_frame_valid), 1);
        tick();
        check_eq("settle5_dfv", 32'(displayed_frame_valid), 1);
        tb_lit = tb_code4[0];
        capture_frame = 1'b1;
        tick();
        capture_frame = 1'b0;
        check_eq("scan_dfv_drop", 32'(displayed_frame_valid), 0);
        for (int c = 0; c < int'(N) + 2; c++) begin
            check_eq("scan_rd", 32'(tbl_rd_addr), (c < int'(N)) ? 32'(c) : 32'(N - 1));
            check_eq("scan_we", 32'(tbl_we), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) check_eq("scan_wr", 32'(tbl_wr_addr), 32'(c - 2));
            if (c == 9)  check_eq("scan_wd7", 32'(tbl_wr_data), 32'd1);
            if (c == 14) check_eq("scan_wd12", 32'(tbl_wr_data), 32'd1);
            tick();
        end
        check_eq("plane1_bit", 32'(current_bit), 1);
        check_eq("plane1_we", 32'(tbl_we), 0);

        do_plane(1);
        check_eq("plane2_bit", 32'(current_bit), 2);
        led_request = 6'd3;
        led_request_valid = 1'b1;
        tick();
        check_eq("led3_cvalid", 32'(color_valid), 1);
        check_eq("led3_rgb", {8'd0, red_out, green_out, blue_out}, 32'h00FFFFFF);
        led_request = 6'd1;
        tick();
        check_eq("led1_rgb", {8'd0, red_out, green_out, blue_out}, 32'h0);
        led_request = 6'd60;
        tick();
        check_eq("led60_cvalid", 32'(color_valid), 1);
        check_eq("led60_rgb", {8'd0, red_out, green_out, blue_out}, 32'h0);
        led_request_valid = 1'b0;
        tick();
        check_eq("idle_cvalid", 32'(color_valid), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_busy_bit", 32'(current_bit), 2);
        check_eq("start_busy_we", 32'(tbl_we), 0);
        do_plane(2);
        for (int p = 3; p < int'(CW); p++) do_plane(p);

        check_eq("done_flag", 32'(done), 1);
        check_eq("done_busy", 32'(busy), 0);
        check_eq("tbl7", 32'(mem[7]), 32'(tb_code4));
        check_eq("tbl12", 32'(mem[12]), 32'd127);
        check_eq("tbl0", 32'(mem[0]), 0);
        led_request = 6'd4;
        led_request_valid = 1'b1;
        tick();
        led_request_valid = 1'b0;
        check_eq("done_led_rgb", {8'd0, red_out, green_out, blue_out}, 32'h0);
        check_eq("done_led_cvalid", 32'(color_valid), 1);

        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart_done", 32'(done), 0);
        check_eq("restart_busy", 32'(busy), 1);
        repeat (N) tick();
        nz = 0;
        for (int i = 0; i < int'(N); i++) if (mem[i] != '0) nz++;
        check_eq("clear_nonzero", nz, 0);

        do_plane(0);
        wait_dfv();
        capture_frame = 1'b1;
        tick();
        capture_frame = 1'b0;
        repeat (5) tick();
        check_eq("midscan_we", 32'(tbl_we), 1);
        led_request = 6'd0;
        led_request_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        led_request_valid = 1'b0;
        check_eq("mrst_busy", 32'(busy), 0);
        check_eq("mrst_we", 32'(tbl_we), 0);
        check_eq("mrst_bit", 32'(current_bit), 0);
        check_eq("mrst_fb", 32'(fb_addr), 0);
        check_eq("mrst_wr", 32'(tbl_wr_addr), 0);
        check_eq("mrst_wd", 32'(tbl_wr_data), 0);
        check_eq("mrst_cvalid", 32'(color_valid), 0);
        check_eq("mrst_rgb", {8'd0, red_out, green_out, blue_out}, 32'h0);
        check_eq("mrst_dfv", 32'(displayed_frame_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cal_sequencer.md
# cal_sequencer

Calibration sequencer for the LED-mapping pipeline. It drives the LED strand through one binary bit-plane per ID bit, one plane at a time. After each captured camera frame it sweeps the thresholded frame buffer and ORs that plane's bit into a per-pixel calibration table. At the end of the run, each table entry holds the code of the LED seen at that pixel; 0 means no LED. It sits between the LED driver, the camera frame buffer and the external dual-port calibration-table BRAM that the HDMI path reads.

## Interface
- NUM_LEDS, 50: LEDs on the strand.
- LED_ADDRESS_WIDTH, 6: LED index width. Code width is CW = LED_ADDRESS_WIDTH+1, which is also the number of bit-planes.
- NUM_FRAME_BUFFER_PIXELS, 64800: table and frame-buffer depth. PW = $clog2(NUM_FRAME_BUFFER_PIXELS).
- SETTLE_CYCLES, 1024: cycles a plane is shown before capture is allowed (≥1).
- ON_COLOR, 24'hFFFFFF / OFF_COLOR, 24'h000000: {R,G,B} for lit and unlit LEDs.
- clk  in  1  system clock
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- start  in  1  pulse; begins a run from IDLE or DONE
- capture_frame  in  1  pulse; camera has latched the displayed plane
- led_request  in  LED_ADDRESS_WIDTH  LED index requested by the strand driver
- led_request_valid  in  1  request strobe
- red_out/green_out/blue_out  out  8 each  colour for the requested LED
- color_valid  out  1  colour valid, one cycle after the request
- displayed_frame_valid  out  1  plane settled; capture is allowed
- fb_addr  out  PW  frame-buffer read address
- fb_data  in  1  thresholded pixel; valid 2 cycles after fb_addr
- tbl_rd_addr  out  PW  table read address
- tbl_rd_data  in  CW  table data; valid 2 cycles after tbl_rd_addr
- tbl_wr_addr  out  PW  table write address
- tbl_wr_data  out  CW  table write data
- tbl_we  out  1  table write enable
- busy  out  1  run in progress (state not IDLE/DONE)
- done  out  1  run complete; held until next start
- current_bit  out  $clog2(CW)  plane index being shown

## Operation
- States: IDLE, CLEAR, SHOW, SCAN, DONE.
- IDLE/DONE, start → CLEAR with bit k=0. In DONE, start clears done.
- CLEAR: writes 0 to addresses 0..N-1, one per cycle, over N cycles, then → SHOW.
- SHOW: the settle counter counts to SETTLE_CYCLES, after which displayed_frame_valid=1.
  - capture_frame with displayed_frame_valid=1 → SCAN.
  - capture_frame before settle is ignored.
- SCAN: for i=0..N-1, issue fb_addr=tbl_rd_addr=i, one per cycle.
  - Two cycles later: tbl_wr_addr=i, tbl_wr_data=tbl_rd_data | (fb_data<<k), tbl_we=1.
  - After the last write: if k==CW-1 → DONE; else k++, settle counter cleared, → SHOW.
- LED code for index j is c(j)=j+1, so 0 is reserved for "no LED".
- Colour response: ON_COLOR when state ∈ {SHOW, SCAN}, j<NUM_LEDS and bit k of code(j) is 1; otherwise OFF_COLOR.
- Request index ≥ NUM_LEDS → OFF_COLOR with color_valid=1.
- start while busy is ignored. led_request is served in every state.
- rst mid-run: immediate IDLE, k=0. Table contents are left partial; the next run's CLEAR wipes them.

## Timing
- Reset: every output is 0 (including colours, tbl_we and addresses). State IDLE, counters 0.
- Colour latency is exactly 1 cycle. color_valid = led_request_valid delayed one cycle. A new request is accepted every cycle.
- CLEAR lasts N cycles; SCAN lasts N+2 cycles; SHOW lasts at least SETTLE_CYCLES+1 cycles.
- displayed_frame_valid drops in the cycle SCAN is entered.
- Read and write addresses are monotonic with write lagging read by 2, so there is no read-during-write hazard.
- current_bit changes in the cycle SHOW is re-entered.
- The last table write occurs in the cycle before done=1.
- Address counters stop at N-1. They never wrap into stray writes.

## Configuration
- CAL_GRAY_EN defined: code(j)=(j+1)^((j+1)>>1), i.e. Gray code. Adjacent LEDs then differ in one plane, which limits mis-decode at blob edges. The table stores Gray codes, and the consumer decodes them.
- Undefined: plain binary code(j)=j+1.

## Structure
- Package cal_pkg holds the state enum cal_state_t and the function led_code(j), which contains the CAL_GRAY_EN switch.
- One sub-module, cal_led_encoder: the registered led_request → colour path, with k and state as inputs.
- Sweep counter, settle counter and the 2-stage RMW pipeline stay in cal_sequencer.

## Test plan
- Reset mid-SCAN → next cycle: state IDLE, tbl_we=0, all outputs 0, current_bit=0.
- N=16, SETTLE_CYCLES=4; capture at 2 cycles into SHOW → ignored; capture at 5 → SCAN; 16 writes observed with addresses 0..15, each 2 cycles after its read.
- Full run, binary mode, pixel 7 lit only in planes where LED 4's code (5=3'b101) has a 1 → table[7]=5; unlit pixel → 0; done=1.
- CAL_GRAY_EN, LED 4 → planes lit per 7=3'b111; table entry = 7.
- led_request=3 (binary code 4), k=2, in SHOW → ON_COLOR next cycle; led_request=60 → OFF_COLOR, color_valid=1.
- start during SHOW → ignored; start in DONE → CLEAR writes zeros to every address, done=0.
